// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder.
//   DW_DEF / N_DEF : default operand width and array dimension
//   state_e        : feeder FSM states (LOAD -> RUN -> HOLD -> LOAD)
//   t_cnt_w()      : width of the run/hold cycle counter, covers 0..3N-1
//   beat_cnt_w()   : width of the load beat counter, covers 0..N
package systolic_pkg;

  localparam int DW_DEF = 8;
  localparam int N_DEF  = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic int t_cnt_w(input int n);
    return $clog2(3 * n);
  endfunction

  function automatic int beat_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int T_W_DEF    = $clog2(3 * N_DEF);
  localparam int BEAT_W_DEF = $clog2(N_DEF + 1);

endpackage

// File: rtl/operand_buffer.sv
// N x N operand register file with a full-row write port and one element
// read per lane.
//   clk_i      : clock
//   we_i       : write row wr_row_i with wr_data_i (element k at [k*DW +: DW])
//   wr_row_i   : row index being written
//   wr_data_i  : row data
//   rd_idx_i   : per-lane element index, lane l at [l*IW +: IW]
//   rd_data_o  : per-lane element, lane l at [l*DW +: DW]
// LANE_IS_ROW selects the read orientation: 1 -> lane l reads mem[l][idx]
// (west edge, A matrix), 0 -> lane l reads mem[idx][l] (north edge, B matrix).
// Contents are plain data and are not reset.
module operand_buffer
  import systolic_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int N           = N_DEF,
  parameter bit LANE_IS_ROW = 1'b1,
  parameter int IW          = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IW-1:0]     wr_row_i,
  input  logic [N*DW-1:0]   wr_data_i,
  input  logic [N*IW-1:0]   rd_idx_i,
  output logic [N*DW-1:0]   rd_data_o
);

  logic [DW-1:0] mem [N][N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_row_i][k] <= wr_data_i[k*DW +: DW];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int l = 0; l < N; l++) begin
      if (LANE_IS_ROW) begin
        rd_data_o[l*DW +: DW] = mem[l][rd_idx_i[l*IW +: IW]];
      end else begin
        rd_data_o[l*DW +: DW] = mem[rd_idx_i[l*IW +: IW]][l];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N output-stationary systolic array.
// Loads N rows of A and B over a valid/ready handshake, then streams them
// into the array edges with the diagonal skew the PEs need, holds for two
// cycles while the last products settle, and pulses done_o when every PE
// accumulator holds its final dot product.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   abort_i             : return to LOAD on the next edge from any state
//   valid_i / ready_o   : load beat handshake (ready only in LOAD)
//   a_row_i / b_row_i   : one row of A / B per beat
//   a_edge_o / b_edge_o : west / north edge operands, one lane per row / col
//   start_bit_o         : PE accumulate enable (PEs clear while low)
//   busy_o              : RUN or HOLD
//   done_o              : one-cycle pulse, PE accumulators final this cycle
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            abort_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [N*DW-1:0] a_row_i,
  input  logic [N*DW-1:0] b_row_i,
  output logic [N*DW-1:0] a_edge_o,
  output logic [N*DW-1:0] b_edge_o,
  output logic            start_bit_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int TW = t_cnt_w(N);
  localparam int BW = beat_cnt_w(N);
  localparam int IW = $clog2(N);

  localparam logic [TW-1:0] T_RUN_LAST = TW'(3*N - 3);
  localparam logic [TW-1:0] T_DONE     = TW'(3*N - 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(N - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          wr_en;

  logic [N*IW-1:0] rd_idx;
  logic [N-1:0]    lane_vld;
  logic [N*DW-1:0] a_rd, b_rd;

  logic [N*DW-1:0] a_edge_p0, b_edge_p0;
  logic            start_p0, done_p0;
  logic [N*DW-1:0] a_edge_p1, b_edge_p1;
  logic            start_p1, done_p1;

  // Operand storage: A read along rows (west edge), B along columns (north).
  operand_buffer #(
    .DW          (DW),
    .N           (N),
    .LANE_IS_ROW (1'b1),
    .IW          (IW)
  ) u_buf_a (
    .clk_i     (clk_i),
    .we_i      (wr_en),
    .wr_row_i  (beat_q[IW-1:0]),
    .wr_data_i (a_row_i),
    .rd_idx_i  (rd_idx),
    .rd_data_o (a_rd)
  );

  operand_buffer #(
    .DW          (DW),
    .N           (N),
    .LANE_IS_ROW (1'b0),
    .IW          (IW)
  ) u_buf_b (
    .clk_i     (clk_i),
    .we_i      (wr_en),
    .wr_row_i  (beat_q[IW-1:0]),
    .wr_data_i (b_row_i),
    .rd_idx_i  (rd_idx),
    .rd_data_o (b_rd)
  );

  // State register: control plus the registered edge/start/done outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_LOAD;
      t_q       <= '0;
      beat_q    <= '0;
      a_edge_p1 <= '0;
      b_edge_p1 <= '0;
      start_p1  <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      beat_q    <= beat_d;
      a_edge_p1 <= a_edge_p0;
      b_edge_p1 <= b_edge_p0;
      start_p1  <= start_p0;
      done_p1   <= done_p0;
    end
  end

  // Next-state logic. abort_i overrides everything except reset, including
  // a beat presented in the same cycle.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    beat_d  = beat_q;
    wr_en   = 1'b0;
    if (abort_i) begin
      state_d = ST_LOAD;
      t_d     = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (valid_i) begin
            wr_en = 1'b1;
            if (beat_q == BEAT_LAST) begin
              state_d = ST_RUN;
              t_d     = '0;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        ST_RUN: begin
          t_d = t_q + TW'(1);
          if (t_q == T_RUN_LAST) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (t_q == T_DONE) begin
            state_d = ST_LOAD;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_LOAD;
          t_d     = '0;
          beat_d  = '0;
        end
      endcase
    end
  end

  // Skew addressing for the upcoming cycle. Lane l of both edges carries
  // element (t - l): A[l][t-l] on the west, B[t-l][l] on the north. The
  // edges are registered from the next counter value so they line up with
  // the state they belong to without an extra cycle of latency. Row N-1 is
  // first needed at t = N-1, so the final beat never has to be bypassed.
  always_comb begin
    rd_idx   = '0;
    lane_vld = '0;
    for (int l = 0; l < N; l++) begin
      int d;
      d = int'(t_d) - l;
      rd_idx[l*IW +: IW] = IW'(d);
      lane_vld[l]        = (state_d == ST_RUN) && (d >= 0) && (d < N);
    end
  end

  // Output logic: values presented on the next edge.
  always_comb begin
    a_edge_p0 = '0;
    b_edge_p0 = '0;
    start_p0  = (state_d != ST_LOAD);
    done_p0   = (state_d == ST_HOLD) && (t_d == T_DONE);
    for (int l = 0; l < N; l++) begin
      if (lane_vld[l]) begin
        a_edge_p0[l*DW +: DW] = a_rd[l*DW +: DW];
        b_edge_p0[l*DW +: DW] = b_rd[l*DW +: DW];
      end
    end
  end

  assign a_edge_o    = a_edge_p1;
  assign b_edge_o    = b_edge_p1;
  assign start_bit_o = start_p1;
  assign done_o      = done_p1;
  assign ready_o     = (state_q == ST_LOAD);
  assign busy_o      = (state_q != ST_LOAD);

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N=4, DW=8). A behavioural model
// tracks "cycles since the run began" and the stored matrices; a PE-array
// model driven by the DUT edges accumulates dot products that are compared
// with a plain matrix multiply when done_o is due.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_i, abort_i, valid_i;
  logic [N*DW-1:0] a_row_i, b_row_i;
  logic            ready_o;
  logic [N*DW-1:0] a_edge_o, b_edge_o;
  logic            start_bit_o, busy_o, done_o;

  always #5 clk = ~clk;

  systolic_feeder #(.DW(DW), .N(N)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .abort_i     (abort_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .a_row_i     (a_row_i),
    .b_row_i     (b_row_i),
    .a_edge_o    (a_edge_o),
    .b_edge_o    (b_edge_o),
    .start_bit_o (start_bit_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int s     = -1;   // cycles since run start, -1 while loading
  int beats = 0;
  int mA [N][N];
  int mB [N][N];
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset_i) begin
      s = -1; beats = 0; chk_en = 1'b1;
    end else if (abort_i) begin
      s = -1; beats = 0;
    end else if (s >= 0) begin
      s++;
      if (s == 3*N) s = -1;
    end else if (valid_i) begin
      for (int k = 0; k < N; k++) begin
        mA[beats][k] = int'(a_row_i[k*DW +: DW]);
        mB[beats][k] = int'(b_row_i[k*DW +: DW]);
      end
      beats++;
      if (beats == N) begin
        s = 0; beats = 0;
      end
    end
  end

  // PE array model fed by the DUT edges
  int pa   [N][N];
  int pb   [N][N];
  int pacc [N][N];

  int last_done = -1000;
  int gap       = -1;
  bit prev_start = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N*DW-1:0] exp_a, exp_b;
      exp_a = '0;
      exp_b = '0;
      for (int l = 0; l < N; l++) begin
        int k;
        k = s - l;
        if (s >= 0 && k >= 0 && k < N) begin
          exp_a[l*DW +: DW] = DW'(mA[l][k]);
          exp_b[l*DW +: DW] = DW'(mB[k][l]);
        end
      end
      check("ready", 64'(ready_o), 64'(s < 0));
      check("busy", 64'(busy_o), 64'(s >= 0));
      check("start_bit", 64'(start_bit_o), 64'(s >= 0));
      check("done", 64'(done_o), 64'(s == 3*N-1));
      check("a_edge", 64'(a_edge_o), 64'(exp_a));
      check("b_edge", 64'(b_edge_o), 64'(exp_b));
      if (s == 3*N-1) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < N; k++) sum += mA[i][k] * mB[k][j];
            check("pe_acc", 64'(pacc[i][j]), 64'(sum));
          end
        end
      end
    end
    for (int i = N-1; i >= 0; i--) begin
      for (int j = N-1; j >= 0; j--) begin
        int ain, bin;
        ain = (j == 0) ? int'(a_edge_o[i*DW +: DW]) : pa[i][j-1];
        bin = (i == 0) ? int'(b_edge_o[j*DW +: DW]) : pb[i-1][j];
        if (start_bit_o !== 1'b1) begin
          pacc[i][j] = 0; pa[i][j] = 0; pb[i][j] = 0;
        end else begin
          pacc[i][j] += ain * bin;
          pa[i][j] = ain;
          pb[i][j] = bin;
        end
      end
    end
    if (done_o === 1'b1) last_done = cyc;
    if (start_bit_o === 1'b1 && !prev_start) gap = cyc - last_done;
    prev_start = (start_bit_o === 1'b1);
  end

  // ---------------- stimulus ----------------
  int sA [N][N];
  int sB [N][N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gaps: 0 none, 1 always one idle cycle before each beat, 2 random
  task automatic load(input int gaps);
    for (int r = 0; r < N; r++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
        valid_i = 1'b0; a_row_i = $urandom; b_row_i = $urandom;
        tick();
      end
      valid_i = 1'b1;
      for (int k = 0; k < N; k++) begin
        a_row_i[k*DW +: DW] = DW'(sA[r][k]);
        b_row_i[k*DW +: DW] = DW'(sB[r][k]);
      end
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic run(input int cycles, input bit noise);
    repeat (cycles) begin
      valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a_row_i = $urandom; b_row_i = $urandom;
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic rand_mats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sA[r][c] = $urandom_range(0, 255);
        sB[r][c] = $urandom_range(0, 255);
      end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_start"}, 64'(start_bit_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_a_edge"}, 64'(a_edge_o), 64'd0);
    check({tag, "_b_edge"}, 64'(b_edge_o), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int skew_exp [10];
    int hi;
    skew_exp = '{0, 0, 0, 'h30, 'h31, 'h32, 'h33, 0, 0, 0};

    reset_i = 1'b1; abort_i = 1'b0; valid_i = 1'b0;
    a_row_i = '0; b_row_i = '0;
    tick(); tick();
    check_idle_outputs("reset");
    reset_i = 1'b0;

    // skew: A[r][k] = 0x10*r + k, B = 0
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sA[r][c] = 16*r + c; sB[r][c] = 0;
      end
    load(0);
    for (int t = 0; t < 3*N; t++) begin
      if (t < 10) check("skew_lane3", 64'(a_edge_o[3*DW +: DW]), 64'(skew_exp[t]));
      tick();
    end

    // full product: identity x B, B[r][c] = r+c+1
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sA[r][c] = (r == c) ? 1 : 0; sB[r][c] = r + c + 1;
      end
    load(0);
    hi = 0;
    for (int t = 0; t < 3*N + 4; t++) begin
      hi += int'(start_bit_o);
      if (t == 3*N-1) begin
        check("prod_done", 64'(done_o), 64'd1);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            check("prod_acc_lit", 64'(pacc[i][j]), 64'(i + j + 1));
      end
      tick();
    end
    check("start_window_len", 64'(hi), 64'd12);

    // handshake with 1-cycle gaps, noise beats during RUN/HOLD
    rand_mats(); load(1); run(3*N, 1'b1);
    rand_mats(); load(1); run(3*N, 1'b1);

    // abort at RUN t=5
    rand_mats(); load(0);
    repeat (5) tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check_idle_outputs("abort");
    abort_i = 1'b1; valid_i = 1'b1; a_row_i = $urandom; b_row_i = $urandom;
    tick();
    abort_i = 1'b0; valid_i = 1'b0;
    rand_mats(); load(0);
    repeat (3*N - 1) tick();
    check("abort_then_done", 64'(done_o), 64'd1);
    tick();

    // reset mid-RUN
    rand_mats(); load(0);
    repeat (4) tick();
    reset_i = 1'b1; tick();
    check_idle_outputs("rst_mid1");
    tick(); reset_i = 1'b0;
    check_idle_outputs("rst_mid2");
    run(3*N, 1'b0);

    // back-to-back
    rand_mats(); load(0);
    repeat (3*N - 1) tick();
    check("b2b_done1", 64'(done_o), 64'd1);
    tick();
    rand_mats(); load(0);
    @(negedge clk); #1;
    check("b2b_gap", 64'(gap), 64'd5);
    run(3*N, 1'b0);

    // randomized loads with gaps, noise and occasional aborts
    repeat (20) begin
      rand_mats(); load(2);
      if ($urandom_range(0, 3) == 0) begin
        run($urandom_range(0, 3*N - 1), 1'b0);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        run(2, 1'b0);
      end else begin
        run(3*N, 1'b1);
      end
    end
    run(4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DW, default 8, operand width in bits, equal to the PE operand width.
REQ-002 SHALL have parameter N, default 4, array dimension (N x N PEs), N >= 2.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port abort_i  input  1  synchronous abort of load or run.
REQ-006 SHALL have port valid_i  input  1  load beat valid.
REQ-007 SHALL have port ready_o  output  1  load beat accepted when valid_i && ready_o.
REQ-008 SHALL have port a_row_i  input  N*DW  row r of matrix A; element k at bits [k*DW +: DW].
REQ-009 SHALL have port b_row_i  input  N*DW  row r of matrix B; element c at bits [c*DW +: DW].
REQ-010 SHALL have port a_edge_o  output  N*DW  west-edge operands, lane r drives PE row r input_a.
REQ-011 SHALL have port b_edge_o  output  N*DW  north-edge operands, lane c drives PE column c input_b.
REQ-012 SHALL have port start_bit_o  output  1  drives start_bit_i of every PE.
REQ-013 SHALL have port busy_o  output  1  high in RUN and HOLD.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse: PE out_accumulator values valid this cycle.

Function
REQ-015 SHALL implement states LOAD, RUN, HOLD; LOAD after reset.
REQ-016 LOAD: ready_o=1; beat count r (0..N-1) increments per accepted beat; a_row_i/b_row_i stored as row r of A/B buffers.
REQ-017 The Nth accepted beat SHALL move the FSM to RUN on the next edge; run counter t starts at 0 in the first RUN cycle.
REQ-018 RUN lasts 3N-2 cycles (t=0..3N-3); ready_o=0; beats presented in RUN or HOLD are ignored, not stored.
REQ-019 In RUN cycle t, lane r of a_edge_o SHALL equal A[r][t-r] if 0 <= t-r < N, else 0.
REQ-020 In RUN cycle t, lane c of b_edge_o SHALL equal B[t-c][c] if 0 <= t-c < N, else 0.
REQ-021 Edge outputs and start_bit_o SHALL be registered, valid in the same cycle as the state/counter they correspond to (no extra latency).
REQ-022 start_bit_o SHALL be 1 in all RUN and HOLD cycles, 0 in LOAD (PEs clear their accumulators while low).
REQ-023 HOLD lasts 2 cycles (t=3N-2, 3N-1); edges 0; done_o=1 only at t=3N-1; then LOAD with beat count 0.
REQ-024 Timing basis: PE(i,j) receives its last operand pair at t=3N-3; its out_accumulator holds the final sum at t=3N-1.
REQ-025 abort_i in any state SHALL on the next edge force LOAD, beat count 0, start_bit_o=0, edges 0, done_o=0; buffer contents need not be cleared.
REQ-026 abort_i and valid_i together in LOAD: abort wins, beat not stored.
REQ-027 A new matrix load SHALL be possible starting the cycle after done_o (back-to-back operations).

Reset
REQ-028 reset_i SHALL dominate abort_i and all other inputs.
REQ-029 Reset values: state LOAD, counters 0, ready_o=1, a_edge_o=0, b_edge_o=0, start_bit_o=0, busy_o=0, done_o=0.
REQ-030 Reset mid-RUN/HOLD SHALL give reset values on the next edge with no done_o pulse.

Structure
REQ-031 Package systolic_pkg SHALL hold DW, N defaults, the state enumeration, and counter widths ($clog2(3N) for t, $clog2(N+1) for beat count).
REQ-032 One sub-module, operand_buffer (N x N x DW register file, row write port, per-lane element read), instanced once for A and once for B.

Verification (N=4, DW=8)
REQ-033 Reset: reset_i high 2 cycles mid-RUN -> next cycle all outputs at reset values, ready_o=1, no done_o.
REQ-034 Skew: A[r][k]=0x10*r+k, B=0 -> lane 3 of a_edge_o is 0 at t=0..2, 0x30 at t=3, 0x33 at t=6, 0 at t=7..9.
REQ-035 Full product: A=identity, B[r][c]=r+c+1 -> start_bit_o high exactly 12 cycles, done_o at t=11, PE(i,j) accumulator = i+j+1.
REQ-036 Handshake: valid_i with 1-cycle gaps -> 4 beats stored in order; beats presented during RUN/HOLD ignored and next result unaffected.
REQ-037 Abort: abort_i at RUN t=5 -> next cycle start_bit_o=0, edges 0, ready_o=1, busy_o=0; subsequent full load gives correct done_o at t=11.
REQ-038 Back-to-back: second load starts the cycle after done_o -> second start_bit_o window begins exactly 5 cycles after first done_o (4 beats + 1 transition edge).
